program_streamer: RTL and testbench

- Producer end of the CPU's 12-bit instruction interface: loads a short program from a host, then issues it one instruction at a time to the CPU core over a valid/ready handshake.
- Replaces the fixed microcode source with a loadable 16-entry program buffer.
- Sits between the host/testbench loader and the CPU's instruction input. Drives the instruction word {opcode[11:8], dst[7:4], src/value[3:0]}.

---
 rtl/program_streamer.sv | 150 +++++++++++++++
 tb/tb_program_streamer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_streamer.sv
// program_streamer: loadable 16-entry program buffer that feeds the CPU's
// 12-bit instruction port over a valid/ready handshake.
// Flow: LOAD (host appends words) -> LOADED -> RUN (issue) -> DONE (replayable).
module program_streamer #(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter int          IW      = 12,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic          inclk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          start,
  input  logic          clear,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_LOADED = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [AW:0] L_FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_LAST_SLOT = (AW+1)'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_next;

  logic [IW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  // One bit wider than the address so that "last entry issued" can be
  // detected as rd_ptr==count even when the buffer is completely full.
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_count;
  logic [IW-1:0] r_instr;
  logic          r_instr_valid;
  logic          r_busy;
  logic          r_done;

  logic          w_load_ready;
  logic          w_wr_fire;
  logic          w_hs;
  logic          w_last_issue;
  logic          w_issue_start;
  logic          w_issue_next;
  logic [AW-1:0] w_rd_addr;

  // Output/control decode from current state and inputs; clear blocks every action.
  always_comb begin
    w_load_ready  = (r_state == S_LOAD);
    w_wr_fire     = load_valid & w_load_ready & ~clear;
    w_hs          = r_instr_valid & instr_ready & (r_state == S_RUN) & ~clear;
    w_last_issue  = (r_instr[IW-1 -: 4] == HALT_OP) || (r_rd_ptr == r_count);
    w_issue_start = start & ~clear & ((r_state == S_LOADED) || (r_state == S_DONE));
    w_issue_next  = w_hs & ~w_last_issue;
    w_rd_addr     = w_issue_start ? '0 : r_rd_ptr[AW-1:0];
  end

  // Next-state logic: clear wins over every other transition.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (w_wr_fire && (load_last || (r_count == L_LAST_SLOT)))
          w_state_next = S_LOADED;
      end
      S_LOADED: begin
        if (w_issue_start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_hs && w_last_issue) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_issue_start) w_state_next = S_RUN;
      end
      default: w_state_next = S_LOAD;
    endcase
    if (clear) w_state_next = S_LOAD;
  end

  // State register with registered busy/done status decoded from the next state.
  always_ff @(posedge inclk) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RUN);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  // Program buffer write port; contents deliberately survive reset and clear.
  always_ff @(posedge inclk) begin
    if (reset && w_wr_fire)
      r_mem[r_wr_ptr] <= load_data;
  end

  // Pointers, count and the registered instruction/valid pair.
  always_ff @(posedge inclk) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else if (clear) begin
      // Pending instruction is withdrawn; instr itself keeps its last value.
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != L_FULL)
          r_count <= r_count + 1'b1;
      end
      if (w_issue_start) begin
        r_instr       <= r_mem[w_rd_addr];
        r_instr_valid <= 1'b1;
        r_rd_ptr      <= (AW+1)'(1);
      end else if (w_issue_next) begin
        r_instr  <= r_mem[w_rd_addr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else if (w_hs) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign load_ready  = w_load_ready;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign count       = r_count;

endmodule

// File: tb/tb_program_streamer.sv
// Directed testbench for program_streamer: inputs change just after the
// falling edge, outputs are checked on the following falling edge.
module tb_program_streamer;

  logic        inclk;
  logic        reset;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        start;
  logic        clear;
  logic [11:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  int n_vec;
  int n_err;

  program_streamer #(
    .DEPTH(16), .AW(4), .IW(12), .HALT_OP(4'hF)
  ) dut (
    .inclk       (inclk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .start       (start),
    .clear       (clear),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  // Present one word for a single cycle; called right after a falling edge.
  task automatic load_word(input logic [11:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(negedge inclk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge inclk);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge inclk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge inclk);
    reset = 1'b1;
    @(negedge inclk);
    n_vec++;
    if ({busy, done, instr_valid, instr, count, load_ready} !== {1'b0, 1'b0, 1'b0, 12'h000, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b valid=%b instr=%h count=%0d ready=%b, want 0 0 0 000 0 1",
               busy, done, instr_valid, instr, count, load_ready);
    end
  endtask

  task automatic test_halt_program();
    logic [11:0] exp [3];
    exp[0] = 12'h705; exp[1] = 12'h712; exp[2] = 12'hF00;
    load_word(12'h705, 1'b0);
    load_word(12'h712, 1'b0);
    load_word(12'hF00, 1'b1);
    n_vec++;
    if (count !== 5'd3 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL halt_loaded: got count=%0d load_ready=%b, want 3 0", count, load_ready);
    end
    pulse_start();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (instr !== exp[i] || instr_valid !== 1'b1 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL halt_issue[%0d]: got instr=%h valid=%b busy=%b, want %h 1 1", i, instr, instr_valid, busy, exp[i]);
      end
      @(negedge inclk);
    end
    instr_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || instr !== 12'hF00) begin
      n_err++;
      $display("FAIL halt_done: got done=%b busy=%b valid=%b instr=%h, want 1 0 0 f00", done, busy, instr_valid, instr);
    end
  endtask

  task automatic test_backpressure_replay();
    pulse_start();
    n_vec++;
    if (instr !== 12'h705 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL replay_first: got instr=%h valid=%b, want 705 1", instr, instr_valid);
    end
    instr_ready = 1'b1;
    @(negedge inclk);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (instr !== 12'h712 || instr_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got instr=%h valid=%b, want 712 1", i, instr, instr_valid);
      end
      if (i < 4) @(negedge inclk);
    end
    instr_ready = 1'b1;
    @(negedge inclk);
    n_vec++;
    if (instr !== 12'hF00 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_resume: got instr=%h valid=%b, want f00 1", instr, instr_valid);
    end
    @(negedge inclk);
    instr_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: got done=%b valid=%b, want 1 0", done, instr_valid);
    end
  endtask

  task automatic test_clear_mid_run();
    pulse_start();
    instr_ready = 1'b1;
    @(negedge inclk);
    n_vec++;
    if (instr !== 12'h712 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL clear_pre: got instr=%h valid=%b, want 712 1", instr, instr_valid);
    end
    pulse_clear();
    instr_ready = 1'b0;
    n_vec++;
    if ({instr_valid, busy, done, load_ready, count} !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL clear_run: got valid=%b busy=%b done=%b ready=%b count=%0d, want 0 0 0 1 0",
               instr_valid, busy, done, load_ready, count);
    end
  endtask

  task automatic test_end_of_buffer();
    pulse_start();
    n_vec++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_load: got busy=%b valid=%b ready=%b, want 0 0 1", busy, instr_valid, load_ready);
    end
    load_word(12'h103, 1'b0);
    load_word(12'h214, 1'b1);
    n_vec++;
    if (count !== 5'd2 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL eob_loaded: got count=%0d ready=%b, want 2 0", count, load_ready);
    end
    pulse_start();
    instr_ready = 1'b1;
    n_vec++;
    if (instr !== 12'h103 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL eob_issue0: got instr=%h valid=%b, want 103 1", instr, instr_valid);
    end
    @(negedge inclk);
    n_vec++;
    if (instr !== 12'h214 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL eob_issue1: got instr=%h valid=%b, want 214 1", instr, instr_valid);
    end
    @(negedge inclk);
    instr_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1 || instr_valid !== 1'b0 || instr !== 12'h214) begin
      n_err++;
      $display("FAIL eob_done: got done=%b valid=%b instr=%h, want 1 0 214", done, instr_valid, instr);
    end
  endtask

  task automatic test_fill();
    pulse_clear();
    for (int i = 0; i < 16; i++) load_word(12'h100 + 12'(i), 1'b0);
    n_vec++;
    if (count !== 5'd16 || load_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL fill_loaded: got count=%0d ready=%b busy=%b, want 16 0 0", count, load_ready, busy);
    end
    load_word(12'hABC, 1'b1);
    n_vec++;
    if (count !== 5'd16 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_17th: got count=%0d ready=%b, want 16 0", count, load_ready);
    end
    pulse_start();
    instr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (instr !== (12'h100 + 12'(i)) || instr_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fill_issue[%0d]: got instr=%h valid=%b, want %h 1", i, instr, instr_valid, 12'h100 + 12'(i));
      end
      @(negedge inclk);
    end
    instr_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fill_done: got done=%b valid=%b, want 1 0", done, instr_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_clear();
    load_word(12'h705, 1'b0);
    load_word(12'h712, 1'b0);
    load_word(12'hF00, 1'b1);
    pulse_start();
    n_vec++;
    if (busy !== 1'b1 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: got busy=%b valid=%b, want 1 1", busy, instr_valid);
    end
    reset = 1'b0;
    @(negedge inclk);
    reset = 1'b1;
    n_vec++;
    if ({busy, done, instr_valid, instr, count, load_ready} !== {1'b0, 1'b0, 1'b0, 12'h000, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid_run: got busy=%b done=%b valid=%b instr=%h count=%0d ready=%b, want 0 0 0 000 0 1",
               busy, done, instr_valid, instr, count, load_ready);
    end
    load_word(12'h123, 1'b1);
    // Glitches on reset that never overlap a rising edge must be ignored.
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge inclk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge inclk);
    n_vec++;
    if (count !== 5'd1 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got count=%0d ready=%b, want 1 0", count, load_ready);
    end
    pulse_start();
    n_vec++;
    if (instr !== 12'h123 || instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async_run: got instr=%h valid=%b, want 123 1", instr, instr_valid);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    start       = 1'b0;
    clear       = 1'b0;
    instr_ready = 1'b0;
    @(negedge inclk);
    test_reset();
    test_halt_program();
    test_backpressure_replay();
    test_clear_mid_run();
    test_end_of_buffer();
    test_fill();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
